neuron_array_core: RTL and testbench

- Time-multiplexed array of N_NEURONS two-state (v, w) FitzHugh-Nagumo-style neurons sharing one Euler-update datapath, in Q(INT_WIDTH).(FRC_WIDTH) signed fixed point.
- Each step_start advances every neuron by one time step, one neuron per clock through a 2-stage pipeline.
- Adds over the single-neuron core: parametrised neuron count and width, state write/readout ports, spike detection, step handshake.
- Instantiates the existing pow_2_function twice (x and -x).

---
 rtl/neuron_array_core.sv | 219 +++++++++++++++++++++
 tb/tb_neuron_array_core.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_array_core.sv
// neuron_array_core: time-multiplexed array of FitzHugh-Nagumo neurons (v, w) sharing one
// Euler-update datapath in signed Q(INT_WIDTH).(FRC_WIDTH) fixed point.
// Latency: a step takes N_NEURONS+1 clocks after the start edge; step_done pulses in the following cycle.
// Backpressure: step_start and wr_en are ignored while busy=1; i_flat must be held while busy.
// Ports: clk/rst_n (async active-low); step_start/busy/step_done step handshake; i_flat packed input
//   currents; spike per-neuron flags; wr_en/wr_idx/wr_v/wr_w state write; rd_idx/rd_v/rd_w registered readout.
// Optional macro NEURON_SPIKE_RESET_EN: a spiking neuron's v is reloaded with V_RST instead of v_next.

// pow_2_function: y = 2^x, x signed Q(INT).(FRC), y unsigned Q(INT).(FRC), saturated to the max positive code.
// 2^frac uses a cubic polynomial; the integer part is applied as a shift.
module pow_2_function #(
  parameter int INT_WIDTH = 3,
  parameter int FRC_WIDTH = 12
) (
  input  logic signed [INT_WIDTH+FRC_WIDTH:0] i_x,
  output logic        [INT_WIDTH+FRC_WIDTH:0] o_y
);
  localparam int          W     = 1 + INT_WIDTH + FRC_WIDTH;
  localparam logic [31:0] ONE   = 32'(2**FRC_WIDTH);
  localparam logic [31:0] C1    = 32'((2**FRC_WIDTH * 6956) / 10000);
  localparam logic [31:0] C2    = 32'((2**FRC_WIDTH * 2262) / 10000);
  localparam logic [31:0] C3    = ONE - C1 - C2;  // coefficients sum to 1 so 2^1 is exact
  localparam logic [63:0] Y_MAX = (64'd1 << (W-1)) - 64'd1;

  logic [31:0]  w_f, w_f2, w_f3, w_m;
  logic [W-1:0] w_ip, w_amt;
  logic [63:0]  w_sh;

  always_comb begin
    w_f   = 32'(i_x[FRC_WIDTH-1:0]);
    w_f2  = (w_f * w_f) >> FRC_WIDTH;
    w_f3  = (w_f2 * w_f) >> FRC_WIDTH;
    w_m   = ONE + ((w_f * C1 + w_f2 * C2 + w_f3 * C3) >> FRC_WIDTH);
    w_ip  = i_x >>> FRC_WIDTH;  // floor of x, so fraction is always non-negative
    w_amt = w_ip[W-1] ? (~w_ip + 1'b1) : w_ip;
    if (w_ip[W-1]) w_sh = {32'd0, w_m} >> w_amt;
    else           w_sh = {32'd0, w_m} << w_amt;
    o_y = (w_sh > Y_MAX) ? Y_MAX[W-1:0] : w_sh[W-1:0];
  end
endmodule

module neuron_array_core #(
  parameter int N_NEURONS  = 4,
  parameter int INT_WIDTH  = 3,
  parameter int FRC_WIDTH  = 12,
  parameter int TAU_SHIFT  = 1,
  parameter int TIME_SHIFT = 7,
  parameter logic [INT_WIDTH+FRC_WIDTH:0]   A_COEF   = 2867,
  parameter logic [INT_WIDTH+FRC_WIDTH+4:0] DEADZONE = 175,
  parameter logic [INT_WIDTH+FRC_WIDTH:0]   V_TH     = 2048,
  parameter logic [INT_WIDTH+FRC_WIDTH:0]   V_RST    = 16'hECE1,
  parameter logic [INT_WIDTH+FRC_WIDTH:0]   W_RST    = 16'hF600,
  localparam int W     = 1 + INT_WIDTH + FRC_WIDTH,
  localparam int IDX_W = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   step_start,
  input  logic [N_NEURONS*W-1:0] i_flat,
  output logic                   busy,
  output logic                   step_done,
  output logic [N_NEURONS-1:0]   spike,
  input  logic                   wr_en,
  input  logic [IDX_W-1:0]       wr_idx,
  input  logic [W-1:0]           wr_v,
  input  logic [W-1:0]           wr_w,
  input  logic [IDX_W-1:0]       rd_idx,
  output logic [W-1:0]           rd_v,
  output logic [W-1:0]           rd_w
);
  localparam int E = W + 4;
  localparam logic signed [E-1:0] DZ    = DEADZONE;
  localparam logic signed [E-1:0] A_E   = {{4{A_COEF[W-1]}}, A_COEF};
  localparam logic signed [E-1:0] RND_V = E'(2**(TIME_SHIFT-1));
  localparam logic signed [E-1:0] RND_W = E'(2**(TAU_SHIFT+TIME_SHIFT-1));
  localparam logic signed [W-1:0] VTH_S = V_TH;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

  state_t                r_state, w_state_nxt;
  logic [IDX_W-1:0]      r_idx, w_idx_nxt;
  logic                  w_capture;
  logic signed [W-1:0]   r_v [N_NEURONS];
  logic signed [W-1:0]   r_w [N_NEURONS];
  logic [N_NEURONS-1:0]  r_spike;
  logic                  r_step_done;
  logic [W-1:0]          r_rd_v, r_rd_w;

  // stage-1 pipeline registers
  logic                  r_s1_vld;
  logic [IDX_W-1:0]      r_s1_idx;
  logic signed [W-1:0]   r_s1_v, r_s1_w, r_s1_i;

  // stage-2 datapath
  logic signed [W-1:0]   w_v_neg, w_v_nxt, w_w_nxt, w_v_wr;
  logic [W-1:0]          w_pp, w_pn;
  logic signed [E-1:0]   w_ve, w_we, w_ie, w_diff, w_z1, w_z2, w_z5raw, w_z5, w_dv, w_z3, w_dw;
  logic                  w_spike;
  logic                  w_unused_hi;

  assign busy      = (r_state != S_IDLE);
  assign step_done = r_step_done;
  assign spike     = r_spike;
  assign rd_v      = r_rd_v;
  assign rd_w      = r_rd_w;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (step_start) begin
          w_state_nxt = S_FETCH;
          w_idx_nxt   = '0;
        end
      end
      S_FETCH: begin
        w_capture = 1'b1;
        if (r_idx == IDX_W'(N_NEURONS-1)) w_state_nxt = S_DRAIN;
        else                              w_idx_nxt   = r_idx + 1'b1;
      end
      S_DRAIN: w_state_nxt = S_IDLE;  // last neuron is written on this edge
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_step_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_step_done <= (r_state == S_DRAIN);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld <= 1'b0;
      r_s1_idx <= '0;
      r_s1_v   <= '0;
      r_s1_w   <= '0;
      r_s1_i   <= '0;
    end else begin
      r_s1_vld <= w_capture;
      if (w_capture) begin
        r_s1_idx <= r_idx;
        r_s1_v   <= r_v[r_idx];
        r_s1_w   <= r_w[r_idx];
        r_s1_i   <= i_flat[r_idx*W +: W];
      end
    end
  end

  assign w_v_neg = -r_s1_v;

  pow_2_function #(.INT_WIDTH(INT_WIDTH), .FRC_WIDTH(FRC_WIDTH)) u_pow_pos (.i_x(r_s1_v),  .o_y(w_pp));
  pow_2_function #(.INT_WIDTH(INT_WIDTH), .FRC_WIDTH(FRC_WIDTH)) u_pow_neg (.i_x(w_v_neg), .o_y(w_pn));

  always_comb begin
    w_ve    = {{4{r_s1_v[W-1]}}, r_s1_v};
    w_we    = {{4{r_s1_w[W-1]}}, r_s1_w};
    w_ie    = {{4{r_s1_i[W-1]}}, r_s1_i};
    w_diff  = $signed({4'd0, w_pn}) - $signed({4'd0, w_pp});
    w_z1    = (w_diff <<< 1) + w_diff;
    w_z2    = (w_ve <<< 2) + w_ve;
    w_z5raw = w_z1 + w_z2 - w_we + w_ie;
    w_z5    = ((w_z5raw > -DZ) && (w_z5raw < DZ)) ? '0 : w_z5raw;
    w_dv    = (w_z5 + RND_V) >>> TIME_SHIFT;
    w_v_nxt = r_s1_v + $signed(w_dv[W-1:0]);
    w_z3    = w_ve + A_E - (w_we >>> 1);
    w_dw    = (w_z3 + RND_W) >>> (TAU_SHIFT + TIME_SHIFT);
    w_w_nxt = r_s1_w + $signed(w_dw[W-1:0]);
    w_spike = (r_s1_v < VTH_S) && (w_v_nxt >= VTH_S);
  end

  // high bits of the increments are dropped: state update wraps to W bits
  assign w_unused_hi = ^{w_dv[E-1:W], w_dw[E-1:W]};

`ifdef NEURON_SPIKE_RESET_EN
  assign w_v_wr = w_spike ? $signed(V_RST) : w_v_nxt;
`else
  assign w_v_wr = w_v_nxt;
`endif

  // stage-2 writes only happen while busy and host writes only while idle, so they never collide
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_NEURONS; k++) begin
        r_v[k] <= V_RST;
        r_w[k] <= W_RST;
      end
      r_spike <= '0;
    end else if (r_s1_vld) begin
      r_v[r_s1_idx]     <= w_v_wr;
      r_w[r_s1_idx]     <= w_w_nxt;
      r_spike[r_s1_idx] <= w_spike;
    end else if (wr_en && !busy && (32'(wr_idx) < N_NEURONS)) begin
      r_v[wr_idx] <= wr_v;
      r_w[wr_idx] <= wr_w;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_v <= V_RST;
      r_rd_w <= W_RST;
    end else if (32'(rd_idx) < N_NEURONS) begin
      r_rd_v <= r_v[rd_idx];
      r_rd_w <= r_w[rd_idx];
    end else begin
      r_rd_v <= '0;
      r_rd_w <= '0;
    end
  end
endmodule

// File: tb/tb_neuron_array_core.sv
// tb_neuron_array_core: self-checking bench for neuron_array_core (N=4, Q3.12).
// Directed vector table, hand-written multi-cycle sequences and randomized steps against a real-valued model.
// Ends with a single summary line.
module tb_neuron_array_core;
  localparam int N = 4;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           step_start;
  logic [N*W-1:0] i_flat;
  logic           busy, step_done;
  logic [N-1:0]   spike;
  logic           wr_en;
  logic [1:0]     wr_idx, rd_idx;
  logic [W-1:0]   wr_v, wr_w, rd_v, rd_w;

  always #5 clk = ~clk;

  neuron_array_core dut (
    .clk(clk), .rst_n(rst_n), .step_start(step_start), .i_flat(i_flat),
    .busy(busy), .step_done(step_done), .spike(spike),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_v(wr_v), .wr_w(wr_w),
    .rd_idx(rd_idx), .rd_v(rd_v), .rd_w(rd_w)
  );

  int n_vec = 0;
  int n_bad = 0;

  typedef struct { int v; int w; int i; int ev; int ew; } vec_t;
  vec_t tbl [8];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_tol(input string name, input int act, input int exp, input int tol);
    n_vec++;
    if (act < exp - tol || act > exp + tol) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d +/- %0d", name, act, exp, tol);
    end
  endtask

  // Reference: real-valued 2^x, then the update equations in plain integer arithmetic.
  task automatic model(input int v, input int w, input int i,
                       output int vn, output int wn, output bit sp, output bit amb);
    int pn, pp, z5, z3;
    pn = $rtoi($floor(4096.0 * (2.0 ** (-v / 4096.0)) + 0.5));
    pp = $rtoi($floor(4096.0 * (2.0 ** ( v / 4096.0)) + 0.5));
    z5 = 3 * (pn - pp) + 5 * v - w + i;
    if (z5 > -175 && z5 < 175) z5 = 0;
    vn  = v + $rtoi($floor((z5 + 64) / 128.0));
    z3  = v + 2867 - $rtoi($floor(w / 2.0));
    wn  = w + $rtoi($floor((z3 + 128) / 256.0));
    sp  = (v < 2048) && (vn >= 2048);
    amb = (v < 2048) && (vn > 2043) && (vn < 2053);
`ifdef NEURON_SPIKE_RESET_EN
    if (sp) vn = -4895;
`endif
  endtask

  task automatic wr_state(input int k, input int v, input int w);
    wr_en = 1'b1; wr_idx = k[1:0]; wr_v = v[15:0]; wr_w = w[15:0];
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic rd_state(input int k, output int v, output int w);
    rd_idx = k[1:0];
    @(posedge clk); #1;
    v = int'($signed(rd_v));
    w = int'($signed(rd_w));
  endtask

  task automatic set_i(input int k, input int val);
    i_flat[k*W +: W] = val[15:0];
  endtask

  // Pulses step_start and checks step_done arrives after edge E(N+1) as a single pulse.
  task automatic run_step();
    int done_at, pulses;
    step_start = 1'b1;
    @(posedge clk); #1;
    step_start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
    done_at = -1; pulses = 0;
    for (int c = 1; c <= N + 4; c++) begin
      @(posedge clk); #1;
      if (step_done) begin
        pulses++;
        if (done_at < 0) done_at = c;
      end
    end
    chk("step_done_cycle", done_at, N + 1);
    chk("step_done_pulses", pulses, 1);
    chk("busy_after_step", int'(busy), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int rv, rw, vn, wn, pulses;
    bit sp, amb;
    int rvs [N], rws [N], ris [N];

    tbl[0] = '{v: 0, w: 0,     i: 4096,  ev: 32,  ew: 11};
    tbl[1] = '{v: 0, w: 0,     i: 100,   ev: 0,   ew: 11};
    tbl[2] = '{v: 0, w: 0,     i: -4096, ev: -32, ew: 11};
    tbl[3] = '{v: 0, w: 0,     i: 175,   ev: 1,   ew: 11};
    tbl[4] = '{v: 0, w: 0,     i: 174,   ev: 0,   ew: 11};
    tbl[5] = '{v: 0, w: 0,     i: -175,  ev: -1,  ew: 11};
    tbl[6] = '{v: 0, w: 4096,  i: 0,     ev: -32, ew: 4099};
    tbl[7] = '{v: 0, w: -4096, i: 0,     ev: 32,  ew: -4077};

    // Reset
    rst_n = 1'b0; step_start = 1'b0; i_flat = '0;
    wr_en = 1'b0; wr_idx = '0; wr_v = '0; wr_w = '0; rd_idx = '0;
    #23;
    chk("reset_busy", int'(busy), 0);
    chk("reset_spike", int'(spike), 0);
    chk("reset_step_done", int'(step_done), 0);
    chk("reset_rd_v", int'(rd_v), 'hECE1);
    chk("reset_rd_w", int'(rd_w), 'hF600);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < N; k++) begin
      rd_state(k, rv, rw);
      chk("reset_v", rv, -4895);
      chk("reset_w", rw, -2560);
    end

    // Directed vector table, four neurons per step
    for (int g = 0; g < 2; g++) begin
      for (int k = 0; k < N; k++) begin
        wr_state(k, tbl[4*g+k].v, tbl[4*g+k].w);
        set_i(k, tbl[4*g+k].i);
      end
      run_step();
      chk("tbl_spike", int'(spike), 0);
      for (int k = 0; k < N; k++) begin
        rd_state(k, rv, rw);
        chk("tbl_v", rv, tbl[4*g+k].ev);
        chk("tbl_w", rw, tbl[4*g+k].ew);
      end
    end

    // Spike on neuron 2; write and step_start on the same edge
    for (int k = 0; k < N; k++) begin
      if (k != 2) wr_state(k, 0, 0);
      set_i(k, 4096);
    end
    wr_en = 1'b1; wr_idx = 2'd2; wr_v = 16'h07F0; wr_w = 16'h0000;
    step_start = 1'b1;
    @(posedge clk); #1;
    wr_en = 1'b0; step_start = 1'b0;
    pulses = 0;
    for (int c = 1; c <= N + 4; c++) begin
      @(posedge clk); #1;
      if (step_done) pulses++;
    end
    chk("spike_step_pulses", pulses, 1);
    chk("spike_flags", int'(spike), 4'b0100);
    rd_state(2, rv, rw);
`ifdef NEURON_SPIKE_RESET_EN
    chk("spike_v_reset", rv, -4895);
`else
    chk_tol("spike_v", rv, 2076, 4);
`endif
    chk("spike_w", rw, 19);
    rd_state(0, rv, rw);
    chk("spike_other_v", rv, 32);

    // Busy lockout: start and write requests during a step are dropped
    wr_state(0, 0, 0);
    set_i(0, 4096);
    step_start = 1'b1;
    @(posedge clk); #1;
    step_start = 1'b0;
    @(posedge clk); #1;
    step_start = 1'b1; wr_en = 1'b1; wr_idx = 2'd0; wr_v = 16'h1234; wr_w = 16'h4321;
    @(posedge clk); #1;
    @(posedge clk); #1;
    step_start = 1'b0; wr_en = 1'b0;
    pulses = 0;
    for (int c = 0; c < 3 * N; c++) begin
      if (step_done) pulses++;
      @(posedge clk); #1;
    end
    chk("lockout_pulses", pulses, 1);
    chk("lockout_busy", int'(busy), 0);
    rd_state(0, rv, rw);
    chk("lockout_v", rv, 32);
    chk("lockout_w", rw, 11);

    // Randomized steps against the model
    for (int r = 0; r < 20; r++) begin
      for (int k = 0; k < N; k++) begin
        rvs[k] = int'($urandom_range(12000)) - 6000;
        rws[k] = int'($urandom_range(12000)) - 6000;
        ris[k] = int'($urandom_range(12000)) - 6000;
        if (r % 4 == 0) rvs[k] = 1900 + int'($urandom_range(147));
        wr_state(k, rvs[k], rws[k]);
        set_i(k, ris[k]);
      end
      run_step();
      for (int k = 0; k < N; k++) begin
        model(rvs[k], rws[k], ris[k], vn, wn, sp, amb);
        rd_state(k, rv, rw);
        if (!amb) begin
          chk_tol("rand_v", rv, vn, 4);
          chk("rand_spike", int'(spike[k]), int'(sp));
        end
        chk("rand_w", rw, wn);
      end
    end

    // Mid-step reset: abort after E2
    for (int k = 0; k < N; k++) wr_state(k, 1000, 500);
    step_start = 1'b1;
    @(posedge clk); #1;
    step_start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #3;
    chk("midrst_busy", int'(busy), 0);
    @(negedge clk); rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < N + 4; c++) begin
      @(posedge clk); #1;
      if (step_done) pulses++;
    end
    chk("midrst_pulses", pulses, 0);
    chk("midrst_spike", int'(spike), 0);
    for (int k = 0; k < N; k++) begin
      rd_state(k, rv, rw);
      chk("midrst_v", rv, -4895);
      chk("midrst_w", rw, -2560);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
